// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared constants and types for the systolic-array FIFO loader.
//   N              array dimension (FIFOs / rows per tile)
//   DW             row width in bits
//   CW             counter width, sized to hold 0..2N-1
//   loader_state_t loader FSM states
//   cnt_t          row / drain-cycle counter type
package sys_arr_pkg;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = $clog2(2 * N);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } loader_state_t;

    typedef logic [CW-1:0] cnt_t;

endpackage

// File: rtl/sysarr_skew_gen.sv
// sysarr_skew_gen: maps the drain cycle counter to per-FIFO shift strobes.
// Build option: SYSARR_LOADER_SKEW_EN
//   defined   -> diagonal skew, FIFO i shifts on cycles i..i+N-1, drain is 2N-1 cycles
//   undefined -> all FIFOs shift together on cycles 0..N-1, drain is N cycles
// Ports:
//   active_i    high while the loader is in DRAIN
//   cyc_cnt_i   current drain cycle
//   shift_o     N-bit shift strobe vector
//   last_o      high on the final drain cycle
module sysarr_skew_gen
    import sys_arr_pkg::*;
(
    input  logic         active_i,
    input  cnt_t         cyc_cnt_i,
    output logic [N-1:0] shift_o,
    output logic         last_o
);

`ifdef SYSARR_LOADER_SKEW_EN
    localparam int unsigned DRAIN_LEN = 2 * N - 1;
`else
    localparam int unsigned DRAIN_LEN = N;
`endif

    logic [31:0] cyc_w;
    assign cyc_w = 32'(cyc_cnt_i);

    always_comb begin
        shift_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
`ifdef SYSARR_LOADER_SKEW_EN
            shift_o[i] = active_i && (cyc_w >= i) && (cyc_w < i + N);
`else
            shift_o[i] = active_i && (cyc_w < N);
`endif
        end
    end

    assign last_o = active_i && (cyc_cnt_i == cnt_t'(DRAIN_LEN - 1));

endmodule

// File: rtl/sysarr_fifo_loader.sv
// sysarr_fifo_loader: steers N incoming matrix rows into N per-row FIFOs,
// then drains them with (optionally skewed) shift strobes.
// Build option: SYSARR_LOADER_SKEW_EN (see sysarr_skew_gen).
// Ports:
//   clk             system clock, rising edge
//   nRST            asynchronous active-low reset
//   in_valid        upstream row valid
//   in_ready        loader can accept a row (low only in DRAIN)
//   in_row          row data
//   fifo_load       one-hot load strobe, bit r loads FIFO r
//   fifo_load_vals  row data broadcast to all FIFOs
//   fifo_shift      per-FIFO shift strobe
//   busy            high in LOAD or DRAIN
//   drain_done      one-cycle pulse the cycle after the final shift
module sysarr_fifo_loader
    import sys_arr_pkg::*;
(
    input  logic          clk,
    input  logic          nRST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_row,
    output logic [N-1:0]  fifo_load,
    output logic [DW-1:0] fifo_load_vals,
    output logic [N-1:0]  fifo_shift,
    output logic          busy,
    output logic          drain_done
);

    localparam cnt_t LAST_ROW = cnt_t'(N - 1);

    loader_state_t state_q, state_d;
    cnt_t          row_cnt_q, row_cnt_d;
    cnt_t          cyc_cnt_q, cyc_cnt_d;
    logic          drain_done_q, drain_done_d;
    logic          acc;
    logic          drain_last;

    assign acc = in_valid & in_ready;

    sysarr_skew_gen u_skew (
        .active_i  (state_q == DRAIN),
        .cyc_cnt_i (cyc_cnt_q),
        .shift_o   (fifo_shift),
        .last_o    (drain_last)
    );

    // State register
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (acc) state_d = (N == 1) ? DRAIN : LOAD;
            LOAD:    if (acc && row_cnt_q == LAST_ROW) state_d = DRAIN;
            DRAIN:   if (drain_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready = (state_q != DRAIN);
        busy     = (state_q != IDLE);
    end

    // Row counter is 0 in IDLE, so the same indexed strobe covers both IDLE and LOAD.
    always_comb begin
        fifo_load = '0;
        for (int unsigned r = 0; r < N; r++) begin
            fifo_load[r] = acc && (row_cnt_q == cnt_t'(r));
        end
    end

    assign fifo_load_vals = in_row;
    assign drain_done     = drain_done_q;

    // Counters and registered completion pulse
    always_comb begin
        row_cnt_d    = row_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        drain_done_d = 1'b0;
        unique case (state_q)
            IDLE, LOAD: begin
                if (acc) begin
                    if (row_cnt_q == LAST_ROW) begin
                        row_cnt_d = '0;
                        cyc_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + cnt_t'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    cyc_cnt_d    = '0;
                    drain_done_d = 1'b1;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + cnt_t'(1);
                end
            end
            default: begin
                row_cnt_d = '0;
                cyc_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            row_cnt_q    <= '0;
            cyc_cnt_q    <= '0;
            drain_done_q <= 1'b0;
        end else begin
            row_cnt_q    <= row_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            drain_done_q <= drain_done_d;
        end
    end

endmodule

// File: tb/tb_sysarr_fifo_loader.sv
// Bench for sysarr_fifo_loader: cycle-level behavioural model plus directed
// scenarios with literal expectations. Honours SYSARR_LOADER_SKEW_EN.
module tb_sysarr_fifo_loader;
    import sys_arr_pkg::*;

`ifdef SYSARR_LOADER_SKEW_EN
    localparam int DLEN = 2 * N - 1;
    localparam logic [3:0] SHIFT_TAB [7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
`else
    localparam int DLEN = N;
    localparam logic [3:0] SHIFT_TAB [4] = '{4'hF, 4'hF, 4'hF, 4'hF};
`endif

    logic          clk = 1'b0;
    logic          nRST = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_row = '0;
    logic [N-1:0]  fifo_load;
    logic [DW-1:0] fifo_load_vals;
    logic [N-1:0]  fifo_shift;
    logic          busy;
    logic          drain_done;

    int n_cmp = 0;
    int n_err = 0;

    sysarr_fifo_loader dut (
        .clk            (clk),
        .nRST           (nRST),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_row         (in_row),
        .fifo_load      (fifo_load),
        .fifo_load_vals (fifo_load_vals),
        .fifo_shift     (fifo_shift),
        .busy           (busy),
        .drain_done     (drain_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: rows loaded so far, drain cycle (-1 when not draining),
    // and the completion pulse.
    int m_loaded = 0;
    int m_dt     = -1;
    bit m_done   = 1'b0;

    always @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            m_loaded = 0;
            m_dt     = -1;
            m_done   = 1'b0;
        end else if (m_dt >= 0) begin
            m_done = (m_dt == DLEN - 1);
            m_dt   = m_done ? -1 : m_dt + 1;
        end else begin
            m_done = 1'b0;
            if (in_valid) begin
                m_loaded++;
                if (m_loaded == N) begin
                    m_loaded = 0;
                    m_dt     = 0;
                end
            end
        end
    end

    function automatic logic [N-1:0] exp_shift();
        logic [N-1:0] s = '0;
        for (int i = 0; i < N; i++) begin
`ifdef SYSARR_LOADER_SKEW_EN
            s[i] = (m_dt >= i) && (m_dt < i + N);
`else
            s[i] = (m_dt >= 0);
`endif
        end
        return s;
    endfunction

    // Compare process: every cycle out of reset, away from the active edge.
    always @(negedge clk) begin
        if (nRST) begin
            chk("m_ready", 32'(in_ready), 32'(m_dt < 0));
            chk("m_busy",  32'(busy), 32'((m_dt >= 0) || (m_loaded > 0)));
            chk("m_load",  32'(fifo_load),
                (in_valid && m_dt < 0) ? (32'd1 << m_loaded) : 32'd0);
            chk("m_vals",  fifo_load_vals, in_row);
            chk("m_shift", 32'(fifo_shift), 32'(exp_shift()));
            chk("m_done",  32'(drain_done), 32'(m_done));
        end
    end

    // Apply inputs just after a rising edge, return at the following falling edge.
    task automatic drive(input logic v, input logic [DW-1:0] row);
        in_valid = v;
        in_row   = row;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic b2b_load(input string tag);
        for (int k = 0; k < N; k++) begin
            drive(1'b1, DW'(32'hA0 + k));
            chk({tag, "_load"}, 32'(fifo_load), 32'd1 << k);
            chk({tag, "_vals"}, fifo_load_vals, 32'hA0 + k);
            next_cycle();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_load"},  32'(fifo_load), 32'd0);
        chk({tag, "_shift"}, 32'(fifo_shift), 32'd0);
        chk({tag, "_done"},  32'(drain_done), 32'd0);
    endtask

    initial begin
        int seen;
        #12;
        nRST = 1'b1;
        next_cycle();

        // Asynchronous reset between edges, mid-LOAD
        drive(1'b1, 32'h11); next_cycle();
        drive(1'b1, 32'h22);
        in_valid = 1'b0;
        #1 nRST = 1'b0;
        #1 check_reset_vals("rst");
        next_cycle();
        nRST = 1'b1;
        next_cycle();

        // Back-to-back load then drain
        b2b_load("b2b");
        for (int t = 0; t < DLEN; t++) begin
            drive(1'b0, '0);
            if (t == 0) chk("b2b_ready_c5", 32'(in_ready), 32'd0);
            chk("drain_shift", 32'(fifo_shift), 32'(SHIFT_TAB[t]));
            chk("drain_nodone", 32'(drain_done), 32'd0);
            next_cycle();
        end
        drive(1'b0, '0);
        chk("drain_done", 32'(drain_done), 32'd1);
        chk("drain_ready", 32'(in_ready), 32'd1);
        chk("drain_shift_off", 32'(fifo_shift), 32'd0);
        next_cycle();

        // Bubbles: valid 1,0,0,1,1,0,1
        begin
            logic [6:0] pat;
            logic [3:0] exp_ld [7];
            pat = 7'b1011001;
            exp_ld = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h4, 4'h0, 4'h8};
            for (int t = 0; t < 7; t++) begin
                drive(pat[t], DW'(32'hB0 + t));
                chk("bub_load", 32'(fifo_load), 32'(exp_ld[t]));
                next_cycle();
            end
        end
        drive(1'b1, 32'hBB);
        chk("bub_drain_ready", 32'(in_ready), 32'd0);
        chk("bub_drain_noload", 32'(fifo_load), 32'd0);
        next_cycle();
        seen = 0;
        for (int t = 0; t < 20 && seen == 0; t++) begin
            drive(1'b0, '0);
            if (drain_done) seen = 1;
            next_cycle();
        end
        chk("bub_done_seen", 32'(seen), 32'd1);

        // Back-to-back load with a row offered during the drain_done cycle
        b2b_load("b2b2");
        for (int t = 0; t < DLEN; t++) begin
            drive(1'b0, '0);
            next_cycle();
        end
        drive(1'b1, 32'hC0);
        chk("done_accept_pulse", 32'(drain_done), 32'd1);
        chk("done_accept_load", 32'(fifo_load), 32'd1);
        next_cycle();
        for (int k = 1; k < N; k++) begin
            drive(1'b1, DW'(32'hC0 + k));
            next_cycle();
        end

        // Reset mid-DRAIN at cyc_cnt == 3
        for (int t = 0; t < 4; t++) begin
            drive(1'b0, '0);
            if (t < 3) next_cycle();
        end
        chk("mid_shift_pre", 32'(fifo_shift), 32'(SHIFT_TAB[3]));
        #1 nRST = 1'b0;
        #1 check_reset_vals("mid_rst");
        next_cycle();
        nRST = 1'b1;
        next_cycle();
        for (int t = 0; t < 3; t++) begin
            drive(1'b0, '0);
            chk("mid_no_done", 32'(drain_done), 32'd0);
            chk("mid_idle", 32'(busy), 32'd0);
            next_cycle();
        end
        b2b_load("post");
        drive(1'b0, '0);
        chk("post_ready", 32'(in_ready), 32'd0);
        next_cycle();
        for (int t = 0; t < 2 * DLEN; t++) begin
            drive(1'b0, '0);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
